ibex_l2_rf_responder: RTL and testbench
=======================================

IBEX_L2_RF_RESPONDER -- requirements
Module: ibex_l2_rf_responder

Interface
REQ-001 SHALL have parameter RV32E, default 0; 1 = 16 architectural words, 0 = 32 words.
REQ-002 SHALL have parameter DataWidth, default 32; width of stored words and data ports.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  input  1  L1-side miss/write-back request valid.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  5  register index.
REQ-009 SHALL have port req_wdata_i  input  DataWidth  write data.
REQ-010 SHALL have port req_id_i  input  2  requester tag, returned unchanged with the response.
REQ-011 SHALL have port rsp_valid_o  output  1  response valid.
REQ-012 SHALL have port rsp_ready_i  input  1  L1 side accepts the response.
REQ-013 SHALL have port rsp_rdata_o  output  DataWidth  read data; 0 for write responses.
REQ-014 SHALL have port rsp_id_o  output  2  tag of the request being answered.
REQ-015 SHALL have port rsp_err_o  output  1  error flag for the response.
REQ-016 SHALL have port init_done_o  output  1  storage clear sequence finished.

Function
REQ-017 SHALL implement FSM states INIT, IDLE and RESP.
REQ-018 In INIT, a 5-bit counter SHALL clear one word per cycle, indices 1..N-1 (N = 16 or 32), then go to IDLE; req_ready_o = 0 and init_done_o = 0 throughout.
REQ-019 A request is accepted on a clock edge where req_valid_i && req_ready_o.
REQ-020 req_ready_o SHALL be 1 in IDLE, and in RESP only while rsp_ready_i = 1 (single-entry pipelined hand-off).
REQ-021 On acceptance, the FSM SHALL move to RESP and the response SHALL be valid the next cycle (latency 1).
REQ-022 In RESP with rsp_ready_i = 1 and no new acceptance, the FSM SHALL return to IDLE; rsp_valid_o, rsp_rdata_o, rsp_id_o and rsp_err_o SHALL be held stable while rsp_ready_i = 0.
REQ-023 A write SHALL commit on its acceptance edge; writes to index 0 SHALL be dropped; a read of index 0 SHALL return 0.
REQ-024 Read data SHALL be captured on the acceptance edge, so a read accepted in the cycle after a write to the same index returns the new data.
REQ-025 With RV32E = 1, addresses >= 16 SHALL return rdata 0 with rsp_err_o = 1, and writes to them SHALL be dropped with rsp_err_o = 1.
REQ-026 Back-to-back acceptance in consecutive cycles SHALL sustain 1 request per cycle while rsp_ready_i = 1.

Reset
REQ-027 When rst_i = 1 at an edge, in any state including mid-RESP, the FSM SHALL enter INIT, any pending response SHALL be discarded, and the counter SHALL be set to 1.
REQ-028 During and after reset the outputs SHALL be: rsp_valid_o = 0, rsp_rdata_o = 0, rsp_id_o = 0, rsp_err_o = 0, req_ready_o = 0, init_done_o = 0 until INIT completes.

Configuration
REQ-029 Macro IBEX_L2RF_PARITY_EN SHALL control parity protection.
REQ-030 When IBEX_L2RF_PARITY_EN is defined, each word SHALL store an even-parity bit written on commit (INIT writes parity 0), and a read whose recomputed parity mismatches SHALL set rsp_err_o = 1 with the raw data returned.
REQ-031 When IBEX_L2RF_PARITY_EN is undefined, no parity storage SHALL exist and rsp_err_o SHALL be driven only by REQ-025.

Verification
REQ-032 Reset release: rst_i = 1 for 2 cycles, then 0 -> init_done_o rises exactly 31 cycles later (RV32E = 0) and 15 cycles later (RV32E = 1); req_ready_o = 0 until then.
REQ-033 Write x5 = 0xDEADBEEF with id 1, then the next cycle read x5 with id 2 -> write response id 1 with rdata 0, then read response id 2 with rdata 0xDEADBEEF, on consecutive cycles.
REQ-034 Write x0 = 0x12345678, then read x0 -> rdata 0, rsp_err_o = 0.
REQ-035 Hold rsp_ready_i = 0 for 3 cycles after a read -> response held stable, req_ready_o = 0, and the response completes in the cycle rsp_ready_i rises.
REQ-036 Assert rst_i while in RESP -> rsp_valid_o = 0 the next cycle, FSM in INIT, and x5 reads 0 after INIT completes.
REQ-037 RV32E = 1, read x20 -> rdata 0, rsp_err_o = 1; with IBEX_L2RF_PARITY_EN defined, a read of x7 after INIT -> rsp_err_o = 0.

Source files
------------

// File: rtl/ibex_l2_rf_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibex_l2_rf_responder
// Description : Register-file backing store that answers L1 miss/write-back
//               requests over a valid/ready request channel and a
//               valid/ready response channel. It holds one response at a time
//               and hands it off in a pipelined way, so one request per cycle
//               is sustained while the response side is ready. After reset,
//               an INIT sequence clears words 1..N-1 one per cycle. Word 0
//               reads as zero and ignores writes.
// Config      : `define IBEX_L2RF_PARITY_EN adds one even-parity bit per word.
//               A read whose stored parity does not match the recomputed
//               parity flags rsp_err_o and still returns the raw data.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_l2_rf_responder #(
  parameter int RV32E     = 0,   // 1: 16 architectural words, 0: 32 words
  parameter int DataWidth = 32   // width of stored words and data ports
) (
  input  logic                 clk_i,
  input  logic                 rst_i,        // synchronous, active-high

  // Request channel (from L1)
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,     // 1 = write, 0 = read
  input  logic [4:0]           req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [1:0]           req_id_i,

  // Response channel (to L1)
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic [1:0]           rsp_id_o,
  output logic                 rsp_err_o,

  output logic                 init_done_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_NUM_WORDS = (RV32E != 0) ? 16 : 32;
  localparam int         c_AW        = (RV32E != 0) ? 4 : 5;
  localparam logic [4:0] c_LAST_IDX  = 5'(c_NUM_WORDS - 1);

  localparam logic [1:0] c_S_INIT = 2'd0;
  localparam logic [1:0] c_S_IDLE = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [4:0]           r_cnt;          // INIT clear pointer

  logic [DataWidth-1:0] r_mem [c_NUM_WORDS];

  logic [DataWidth-1:0] r_rsp_rdata;
  logic [1:0]           r_rsp_id;
  logic                 r_rsp_err;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic                 w_accept;
  logic                 w_addr_oob;     // index beyond the architectural file
  logic                 w_addr_zero;
  logic [c_AW-1:0]      w_idx;
  logic [c_AW-1:0]      w_init_idx;
  logic                 w_req_wr;
  logic                 w_init_wr;
  logic [DataWidth-1:0] w_rd_word;
  logic [DataWidth-1:0] w_rd_data;
  logic                 w_rsp_err;

  assign w_accept    = req_valid_i & req_ready_o;
  // Only the reduced file has out-of-range indices; bit 4 selects x16..x31.
  assign w_addr_oob  = (RV32E != 0) && req_addr_i[4];
  assign w_addr_zero = (req_addr_i == 5'd0);
  assign w_idx       = req_addr_i[c_AW-1:0];
  assign w_init_idx  = r_cnt[c_AW-1:0];

  // Writes commit on the acceptance edge unless they target x0 or fall outside
  // the file. A reset on the same edge wins and suppresses the write.
  assign w_req_wr  = w_accept & req_we_i & ~w_addr_oob & ~w_addr_zero & ~rst_i;
  assign w_init_wr = (r_state == c_S_INIT) & ~rst_i;

  // Reads sample the array on their acceptance edge, so a write committed on
  // the previous edge is already visible. Writes, x0 and out-of-range reads
  // all answer with zero data.
  assign w_rd_word = r_mem[w_idx];
  assign w_rd_data = (req_we_i | w_addr_oob | w_addr_zero) ? '0 : w_rd_word;

`ifdef IBEX_L2RF_PARITY_EN
  // --------------------------------------------------------------------------
  // Parity protection
  // --------------------------------------------------------------------------
  logic r_par [c_NUM_WORDS];
  logic w_par_err;

  // Only genuine storage reads are checked; x0 and out-of-range reads have no
  // backing word, and writes return no data.
  assign w_par_err = ~req_we_i & ~w_addr_oob & ~w_addr_zero &
                     ((^w_rd_word) != r_par[w_idx]);
  assign w_rsp_err = w_addr_oob | w_par_err;

  // Parity bits track the data array: INIT stores 0 (parity of an all-zero
  // word), a committed write stores the even parity of its data.
  always_ff @(posedge clk_i) begin
    if (w_init_wr) begin
      r_par[w_init_idx] <= 1'b0;
    end else if (w_req_wr) begin
      r_par[w_idx] <= ^req_wdata_i;
    end
  end
`else
  assign w_rsp_err = w_addr_oob;
`endif

  // Data array: INIT clears one word per cycle, otherwise accepted writes.
  always_ff @(posedge clk_i) begin
    if (w_init_wr) begin
      r_mem[w_init_idx] <= '0;
    end else if (w_req_wr) begin
      r_mem[w_idx] <= req_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register; reset from any state restarts the clear sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      c_S_INIT: begin
        if (r_cnt == c_LAST_IDX) begin
          w_state_next = c_S_IDLE;
        end
      end
      c_S_IDLE: begin
        if (w_accept) begin
          w_state_next = c_S_RESP;
        end
      end
      c_S_RESP: begin
        // A new acceptance here replaces the departing response in place.
        if (w_accept) begin
          w_state_next = c_S_RESP;
        end else if (rsp_ready_i) begin
          w_state_next = c_S_IDLE;
        end
      end
      default: begin
        w_state_next = c_S_INIT;
      end
    endcase
  end

  // Output decode: ready in IDLE, or in RESP when the held response leaves.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    init_done_o = 1'b0;
    unique case (r_state)
      c_S_IDLE: begin
        req_ready_o = 1'b1;
        init_done_o = 1'b1;
      end
      c_S_RESP: begin
        req_ready_o = rsp_ready_i;
        rsp_valid_o = 1'b1;
        init_done_o = 1'b1;
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

  // INIT clear pointer: starts at 1 because x0 has no backing storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 5'd1;
    end else if (r_state == c_S_INIT) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Response payload: captured on acceptance, held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_rdata <= '0;
      r_rsp_id    <= 2'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_rdata <= w_rd_data;
      r_rsp_id    <= req_id_i;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ibex_l2_rf_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_l2_rf_responder
// Description : Self-checking bench. Instance A uses the full 32-word file and
//               is compared against a transaction-level model (word array plus
//               one pending-response slot). Instance B uses the 16-word file
//               and is checked against constant expectation tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_l2_rf_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- Instance A (RV32E = 0) ----------------
  logic        rst_a = 1'b1;
  logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b1;
  logic [4:0]  a_req_addr = 5'd0;
  logic [31:0] a_req_wdata = 32'd0;
  logic [1:0]  a_req_id = 2'd0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_init_done;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_rsp_id;

  ibex_l2_rf_responder #(.RV32E(0), .DataWidth(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_id_i(a_req_id),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
    .rsp_id_o(a_rsp_id), .rsp_err_o(a_rsp_err), .init_done_o(a_init_done)
  );

  // ---------------- Instance B (RV32E = 1) ----------------
  logic        rst_b = 1'b1;
  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
  logic [4:0]  b_req_addr = 5'd0;
  logic [31:0] b_req_wdata = 32'd0;
  logic [1:0]  b_req_id = 2'd0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;
  logic [31:0] b_rsp_rdata;
  logic [1:0]  b_rsp_id;

  ibex_l2_rf_responder #(.RV32E(1), .DataWidth(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_id_i(b_req_id),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .rsp_id_o(b_rsp_id), .rsp_err_o(b_rsp_err), .init_done_o(b_init_done)
  );

  // ---------------- Reference model for A ----------------
  logic [31:0] m_mem [32];
  bit          m_pend  = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_id    = 2'd0;
  bit          m_err   = 1'b0;

  task automatic model_reset_a();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_pend = 1'b0; m_rdata = 32'd0; m_id = 2'd0; m_err = 1'b0;
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_edge_a();
    bit acc;
    acc = a_req_valid && (!m_pend || a_rsp_ready);
    if (acc) begin
      m_pend = 1'b1;
      m_id   = a_req_id;
      m_err  = 1'b0;
      if (a_req_we) begin
        if (a_req_addr != 5'd0) m_mem[a_req_addr] = a_req_wdata;
        m_rdata = 32'd0;
      end else begin
        m_rdata = (a_req_addr == 5'd0) ? 32'd0 : m_mem[a_req_addr];
      end
    end else if (a_rsp_ready) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic drive_a(input bit v, input bit we, input logic [4:0] ad,
                         input logic [31:0] wd, input logic [1:0] id, input bit rr);
    a_req_valid = v; a_req_we = we; a_req_addr = ad;
    a_req_wdata = wd; a_req_id = id; a_rsp_ready = rr;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    int a_cyc, b_cyc;
    bit early_ready;
    a_cyc = 0; b_cyc = 0; early_ready = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1);
    b_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if ({a_rsp_valid, a_rsp_rdata, a_rsp_id, a_rsp_err, a_req_ready, a_init_done} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_a got v=%b d=%h id=%0d e=%b rdy=%b done=%b exp all 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_id, a_rsp_err, a_req_ready, a_init_done);
    end
    n_tests++;
    if ({b_rsp_valid, b_rsp_rdata, b_rsp_id, b_rsp_err, b_req_ready, b_init_done} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_b got v=%b d=%h id=%0d e=%b rdy=%b done=%b exp all 0",
               b_rsp_valid, b_rsp_rdata, b_rsp_id, b_rsp_err, b_req_ready, b_init_done);
    end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (a_init_done && a_cyc == 0) a_cyc = cyc;
      if (b_init_done && b_cyc == 0) b_cyc = cyc;
      if ((!a_init_done && a_req_ready) || (!b_init_done && b_req_ready)) early_ready = 1'b1;
    end
    n_tests++;
    if (a_cyc != 31) begin
      n_fail++; $display("FAIL init_latency_a got %0d cycles exp 31", a_cyc);
    end
    n_tests++;
    if (b_cyc != 15) begin
      n_fail++; $display("FAIL init_latency_b got %0d cycles exp 15", b_cyc);
    end
    n_tests++;
    if (early_ready) begin
      n_fail++; $display("FAIL ready_during_init got 1 exp 0");
    end
    model_reset_a();
  endtask

  task automatic test_write_read();
    @(negedge clk); drive_a(1, 1, 5'd5, 32'hDEADBEEF, 2'd1, 1); #1;
    n_tests++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_idle_state got rdy=%b v=%b exp rdy=1 v=0", a_req_ready, a_rsp_valid);
    end
    model_edge_a();
    @(negedge clk); drive_a(1, 0, 5'd5, 32'd0, 2'd2, 1); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd1 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_response got v=%b id=%0d d=%h e=%b exp v=1 id=1 d=0 e=0",
                         a_rsp_valid, a_rsp_id, a_rsp_rdata, a_rsp_err);
    end
    model_edge_a();
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd2 || a_rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL raw_read_response got v=%b id=%0d d=%h exp v=1 id=2 d=deadbeef",
                         a_rsp_valid, a_rsp_id, a_rsp_rdata);
    end
    model_edge_a();
    @(negedge clk); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_drain got v=%b exp 0", a_rsp_valid);
    end
  endtask

  task automatic test_x0();
    @(negedge clk); drive_a(1, 1, 5'd0, 32'h12345678, 2'd3, 1); #1; model_edge_a();
    @(negedge clk); drive_a(1, 0, 5'd0, 32'd0, 2'd0, 1); #1; model_edge_a();
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0 || a_rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL x0_read got v=%b d=%h e=%b id=%0d exp v=1 d=0 e=0 id=0",
                         a_rsp_valid, a_rsp_rdata, a_rsp_err, a_rsp_id);
    end
    model_edge_a();
  endtask

  task automatic test_stall();
    @(negedge clk); drive_a(1, 0, 5'd5, 32'd0, 2'd3, 1); #1; model_edge_a();
    for (int k = 0; k < 3; k++) begin
      // A competing request is offered while stalled; it must not be taken.
      @(negedge clk); drive_a(1, 0, 5'd9, 32'd0, 2'd0, 0); #1;
      n_tests++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || a_rsp_id !== 2'd3 ||
          a_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b d=%h id=%0d rdy=%b exp v=1 d=deadbeef id=3 rdy=0",
                           k, a_rsp_valid, a_rsp_rdata, a_rsp_id, a_req_ready);
      end
      model_edge_a();
    end
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stall_release got v=%b rdy=%b d=%h exp v=1 rdy=1 d=deadbeef",
                         a_rsp_valid, a_req_ready, a_rsp_rdata);
    end
    model_edge_a();
    @(negedge clk); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_complete got v=%b exp 0", a_rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n_rsp;
    n_rsp = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 10) drive_a(1, (i % 2) == 0, 5'(10 + i / 2), $urandom, 2'(i), 1);
      else        drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1);
      #1;
      if (a_rsp_valid) n_rsp++;
      n_tests++;
      if (a_req_ready !== 1'b1 || a_rsp_valid !== m_pend ||
          (m_pend && (a_rsp_rdata !== m_rdata || a_rsp_id !== m_id))) begin
        n_fail++; $display("FAIL b2b[%0d] got rdy=%b v=%b d=%h id=%0d exp rdy=1 v=%b d=%h id=%0d",
                           i, a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_id, m_pend, m_rdata, m_id);
      end
      model_edge_a();
    end
    n_tests++;
    if (n_rsp != 10) begin
      n_fail++; $display("FAIL b2b_throughput got %0d responses exp 10", n_rsp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive_a($urandom_range(0, 9) < 7, $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
              $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (a_rsp_valid !== m_pend || a_req_ready !== (!m_pend || a_rsp_ready) ||
          (m_pend && (a_rsp_rdata !== m_rdata || a_rsp_id !== m_id || a_rsp_err !== m_err))) begin
        n_fail++; $display("FAIL random[%0d] got v=%b rdy=%b d=%h id=%0d e=%b exp v=%b rdy=%b d=%h id=%0d e=%b",
                           i, a_rsp_valid, a_req_ready, a_rsp_rdata, a_rsp_id, a_rsp_err,
                           m_pend, (!m_pend || a_rsp_ready), m_rdata, m_id, m_err);
      end
      model_edge_a();
    end
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); #1; model_edge_a();
    @(negedge clk); #1;
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk); drive_a(1, 1, 5'd5, 32'hCAFEF00D, 2'd0, 1); #1; model_edge_a();
    @(negedge clk); drive_a(1, 0, 5'd5, 32'd0, 2'd1, 1); #1; model_edge_a();
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); rst_a = 1'b1; #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL pre_reset_resp got v=%b d=%h exp v=1 d=cafef00d", a_rsp_valid, a_rsp_rdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({a_rsp_valid, a_rsp_rdata, a_rsp_id, a_rsp_err, a_req_ready, a_init_done} !== 38'd0) begin
      n_fail++; $display("FAIL reset_mid_resp got v=%b d=%h id=%0d e=%b rdy=%b done=%b exp all 0",
                         a_rsp_valid, a_rsp_rdata, a_rsp_id, a_rsp_err, a_req_ready, a_init_done);
    end
    @(negedge clk); rst_a = 1'b0;
    for (int i = 0; i < 40 && !a_init_done; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (a_init_done !== 1'b1) begin
      n_fail++; $display("FAIL reinit_timeout got done=%b exp 1", a_init_done);
    end
    model_reset_a();
    @(negedge clk); drive_a(1, 0, 5'd5, 32'd0, 2'd1, 1); #1; model_edge_a();
    @(negedge clk); drive_a(0, 0, 5'd0, 32'd0, 2'd0, 1); #1;
    n_tests++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'd0 || a_rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL x5_after_reinit got v=%b d=%h id=%0d exp v=1 d=0 id=1",
                         a_rsp_valid, a_rsp_rdata, a_rsp_id);
    end
    model_edge_a();
  endtask

  task automatic test_rv32e();
    bit          t_we  [6] = '{0, 1, 0, 0, 1, 0};
    logic [4:0]  t_ad  [6] = '{5'd20, 5'd20, 5'd4, 5'd7, 5'd7, 5'd7};
    logic [31:0] t_wd  [6] = '{32'd0, 32'hA5A5A5A5, 32'd0, 32'd0, 32'h0F0F1234, 32'd0};
    logic [31:0] e_d   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0F0F1234};
    bit          e_err [6] = '{1, 1, 0, 0, 0, 0};
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) begin
        b_req_valid = 1'b1; b_req_we = t_we[i]; b_req_addr = t_ad[i];
        b_req_wdata = t_wd[i]; b_req_id = 2'(i);
      end else begin
        b_req_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        n_tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== e_d[i-1] || b_rsp_err !== e_err[i-1] ||
            b_rsp_id !== 2'(i - 1)) begin
          n_fail++; $display("FAIL rv32e[%0d] got v=%b d=%h e=%b id=%0d exp v=1 d=%h e=%b id=%0d",
                             i - 1, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_rsp_id,
                             e_d[i-1], e_err[i-1], i - 1);
        end
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (b_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rv32e_drain got v=%b exp 0", b_rsp_valid);
    end
  endtask

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset_a();
    test_reset();
    test_write_read();
    test_x0();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_in_resp();
    test_rv32e();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
